// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
// The master side feeds bytes and observes the memory writes (the
// boot host and the instruction memory). The slave side is the loader.
interface imem_loader_if #(
   parameter int ADDR_W = 7
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Accepts LEN_LO, LEN_HI (word count N), then 4*N little-endian data bytes,
// writes each assembled word to consecutive word addresses from 0 and keeps
// the core in reset until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte; a mismatch aborts into the error state.
module imem_loader #(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   imem_loader_if.slave bus,
   output logic         core_reset_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   // Loading states: the stream is being consumed and the core is held.
   function automatic logic is_busy(input state_t s);
      return !(s inside {S_IDLE, S_DONE, S_ERR});
   endfunction

   state_t            state_q, state_d;
   logic              drain_q, drain_d;
   logic              rx_ready_q;
   logic              busy_q;
   logic              core_reset_q;
   logic              done_q;
   logic              err_q;

   logic [7:0]        len_lo_q;
   logic [ADDR_W-1:0] len_m1_q;
   logic [ADDR_W-1:0] word_idx_q;
   logic [1:0]        byte_idx_q;
   logic [23:0]       asm_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic        accept;
   logic        start_go;
   logic [15:0] len_w;
   logic        len_ok;
   logic        word_done;
   logic        last_word;

   assign accept    = bus.rx_valid && rx_ready_q;
   assign start_go  = start_i && !is_busy(state_q);
   assign len_w     = {bus.rx_data, len_lo_q};
   assign len_ok    = (len_w != 16'd0) && ({16'd0, len_w} <= 32'(DEPTH));
   assign word_done = accept && (state_q == S_DATA) && (byte_idx_q == 2'd3);
   assign last_word = (word_idx_q == len_m1_q);

   // Next-state selection. Without the checksum, the final word takes one
   // extra DATA cycle (drain) so DONE follows the last write pulse.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      drain_d = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: if (start_i) state_d = S_LEN_LO;
         S_LEN_LO:              if (accept) state_d = S_LEN_HI;
         S_LEN_HI:              if (accept) state_d = len_ok ? S_DATA : S_ERR;
         S_DATA: begin
            if (drain_q) begin
               state_d = S_DONE;
            end else if (word_done && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               drain_d = 1'b1;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: if (accept) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State register with all status outputs registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         drain_q      <= 1'b0;
         rx_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state_q      <= state_d;
         drain_q      <= drain_d;
         rx_ready_q   <= is_busy(state_d) && !drain_d;
         busy_q       <= is_busy(state_d);
         core_reset_q <= (state_d != S_DONE);
         done_q       <= (state_d == S_DONE);
         err_q        <= (state_d == S_ERR);
      end
   end

   // Length capture, word assembly, write strobe and checksum accumulation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_lo_q   <= '0;
         len_m1_q   <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         asm_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         we_q <= 1'b0;
         if (start_go) begin
            word_idx_q <= '0;
            byte_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
         end
         if (accept) begin
            case (state_q)
               S_LEN_LO: len_lo_q <= bus.rx_data;
               S_LEN_HI: len_m1_q <= ADDR_W'(len_w - 16'd1);
               S_DATA: begin
                  byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q     <= csum_q ^ bus.rx_data;
`endif
                  case (byte_idx_q)
                     2'd0: asm_q[7:0]   <= bus.rx_data;
                     2'd1: asm_q[15:8]  <= bus.rx_data;
                     2'd2: asm_q[23:16] <= bus.rx_data;
                     default: begin
                        wdata_q <= {bus.rx_data, asm_q};
                        addr_q  <= word_idx_q;
                        we_q    <= 1'b1;
                        if (!last_word) word_idx_q <= word_idx_q + 1'b1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.rx_ready   = rx_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign core_reset_o   = core_reset_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver pushes each expected
// memory write as it streams a word; independent monitors predict write
// timing from observed byte accepts and pop/compare every write strobe.
module tb_imem_loader;
   localparam int DEPTH  = 128;
   localparam int ADDR_W = 7;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic core_reset, busy, done, err;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start),
      .bus         (bus),
      .core_reset_o(core_reset),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   wr_t         exp_q[$];
   logic [31:0] tb_mem     [DEPTH];
   logic [31:0] stim_words [DEPTH];
   bit          drv_b3, drv_last, pend_b3, pend_last, done_chk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Predict: a byte flagged as the 4th of a word will be accepted at the next edge.
   always @(negedge clk) begin
      #2;
      pend_b3   = bus.rx_valid && bus.rx_ready && drv_b3 && !reset;
      pend_last = pend_b3 && drv_last;
   end

   // Memory model plus scoreboard: every write strobe is popped and compared.
   always @(posedge clk) begin
      wr_t e;
      #2;
      if (done_chk) begin
         check("done_after_last_write", done, 1);
         check("core_release_after_last_write", core_reset, 0);
         done_chk = 0;
      end
      if (bus.imem_we || pend_b3) begin
         check("we_one_cycle_after_byte3", bus.imem_we, pend_b3);
         if (bus.imem_we) begin
            tb_mem[bus.imem_addr] = bus.imem_wdata;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: addr %h data %h", bus.imem_addr, bus.imem_wdata);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
               check("write_data", bus.imem_wdata, e.data);
`ifndef IMEM_LOADER_CHECKSUM_EN
               if (pend_last) begin
                  check("done_low_during_last_write", done, 0);
                  done_chk = 1;
               end
`endif
            end
         end
      end
   end

   // Send one byte after an idle gap; returns on the negedge after its accept.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit b3,
                            input bit last, input bit pulse_start);
      int n;
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      drv_b3       = b3;
      drv_last     = last;
      if (pulse_start) start = 1'b1;
      n = 0;
      while (!bus.rx_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rx_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL rx_ready_timeout: rx_ready %b required 1", bus.rx_ready);
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
      drv_b3       = 1'b0;
      drv_last     = 1'b0;
      start        = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_rx_ready", bus.rx_ready, 1);
      check("start_core_reset", core_reset, 1);
      check("start_done_cleared", done, 0);
      check("start_err_cleared", err, 0);
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || err) && n < 32) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Full load of stim_words[0..n-1]; expected result from the stream rules.
   task automatic load(input int n, input bit bad_csum, input int gapmax, input int start_at);
      logic [7:0] x, b;
      bit ok;
      do_start();
      send_byte(n[7:0], $urandom_range(gapmax, 0), 0, 0, 0);
      send_byte(n[15:8], $urandom_range(gapmax, 0), 0, 0, 0);
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = stim_words[i][8*k +: 8];
            x ^= b;
            if (k == 3) exp_q.push_back('{addr: ADDR_W'(i), data: stim_words[i]});
            send_byte(b, $urandom_range(gapmax, 0), k == 3, (k == 3) && (i == n - 1),
                      (i * 4 + k) == start_at);
         end
      end
      ok = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? (x ^ 8'h01) : x, $urandom_range(gapmax, 0), 0, 0, 0);
      ok = !bad_csum;
`endif
      wait_end();
      check("end_done", done, 32'(ok));
      check("end_err", err, 32'(!ok));
      check("end_core_reset", core_reset, 32'(!ok));
      check("end_busy", busy, 0);
      check("end_rx_ready", bus.rx_ready, 0);
      for (int i = 0; i < n; i++) check("mem_word", tb_mem[i], stim_words[i]);
   endtask

   task automatic bad_len(input logic [7:0] lo, input logic [7:0] hi);
      do_start();
      send_byte(lo, 0, 0, 0, 0);
      send_byte(hi, 0, 0, 0, 0);
      check("badlen_err", err, 1);
      check("badlen_done", done, 0);
      check("badlen_rx_ready", bus.rx_ready, 0);
      check("badlen_busy", busy, 0);
      check("badlen_core_reset", core_reset, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) stim_words[i] = $urandom;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      drv_b3       = 1'b0;
      drv_last     = 1'b0;
      done_chk     = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rx_ready", bus.rx_ready, 0);
      check("rst_we", bus.imem_we, 0);
      check("rst_addr", 32'(bus.imem_addr), 0);
      check("rst_wdata", bus.imem_wdata, 0);
      check("rst_core_reset", core_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      reset = 1'b0;
      @(negedge clk);

      // Reference two-instruction image, good and (when present) bad checksum.
      stim_words[0] = 32'h0000_0013;
      stim_words[1] = 32'h00A0_0093;
      load(2, 0, 0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      load(2, 1, 0, -1);
`endif

      // Illegal lengths: zero, DEPTH+1, 256, maximum 16-bit.
      bad_len(8'h00, 8'h00);
      bad_len(8'h81, 8'h00);
      bad_len(8'h00, 8'h01);
      bad_len(8'hFF, 8'hFF);

      // Single-word images with random valid gaps (start from ERR/DONE).
      for (int r = 0; r < 6; r++) begin
         fill_random(1);
         load(1, 0, 3, -1);
      end

      // Random images; start pulsed mid-data must be ignored.
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(8, 1);
         fill_random(n);
         load(n, 0, 3, (r % 2 == 0) ? int'($urandom_range(4 * n - 1, 1)) : -1);
      end

      // Largest legal image.
      fill_random(DEPTH);
      load(DEPTH, 0, 0, -1);

      // Reset after five data bytes: outputs drop at once, word 0 stays.
      fill_random(2);
      do_start();
      send_byte(8'h02, 0, 0, 0, 0);
      send_byte(8'h00, 0, 0, 0, 0);
      exp_q.push_back('{addr: '0, data: stim_words[0]});
      for (int k = 0; k < 4; k++) send_byte(stim_words[0][8*k +: 8], 0, k == 3, 0, 0);
      send_byte(stim_words[1][7:0], 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      check("midrst_rx_ready", bus.rx_ready, 0);
      check("midrst_we", bus.imem_we, 0);
      check("midrst_addr", 32'(bus.imem_addr), 0);
      check("midrst_wdata", bus.imem_wdata, 0);
      check("midrst_core_reset", core_reset, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_err", err, 0);
      check("midrst_mem0_kept", tb_mem[0], stim_words[0]);
      check("midrst_scoreboard_empty", 32'(exp_q.size()), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      fill_random(3);
      load(3, 0, 2, -1);

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
